// File: rtl/mult_complex_e_pipe_if.sv
// Sample/result bundle for the pipelined complex rotator mult_complex_e_pipe.
// The master drives samples and control; the slave (the rotator) returns results.
interface mult_complex_e_pipe_if #(
    parameter int LOG2N  = 4,
    parameter int DATA_W = 16
);
    logic                     en;
    logic                     in_valid;
    logic                     inv;
    logic signed [DATA_W-1:0] in_data_i;
    logic signed [DATA_W-1:0] in_data_q;
    logic [LOG2N-1:0]         fi_idx;

    logic signed [DATA_W-1:0] out_data_minus_i;
    logic signed [DATA_W-1:0] out_data_minus_q;
    logic signed [DATA_W-1:0] out_data_plus_i;
    logic signed [DATA_W-1:0] out_data_plus_q;
    logic [LOG2N-1:0]         out_idx;
    logic                     out_valid;

    modport master (
        output en, in_valid, inv, in_data_i, in_data_q, fi_idx,
        input  out_data_minus_i, out_data_minus_q, out_data_plus_i, out_data_plus_q,
        input  out_idx, out_valid
    );

    modport slave (
        input  en, in_valid, inv, in_data_i, in_data_q, fi_idx,
        output out_data_minus_i, out_data_minus_q, out_data_plus_i, out_data_plus_q,
        output out_idx, out_valid
    );
endinterface

// File: rtl/mult_complex_e_pipe.sv
// 4-stage complex rotator: x*e^(-j2pi k/N) and x*e^(+j2pi k/N) from a quarter-wave cosine ROM.
// Define ROT_ROUND_EN for round-half-up scaling; default is floor (truncating) scaling.
module mult_complex_e_pipe #(
    parameter int LOG2N  = 4,
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input logic                clk,
    input logic                rst,
    mult_complex_e_pipe_if.slave bus
);
    localparam int N  = 1 << LOG2N;
    localparam int QN = N / 4;
    localparam int AW = LOG2N - 1;
    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;
    localparam int SH = TW_W - 1;
    localparam int RW = SW - SH;

    localparam longint AMP    = (64'sd1 <<< (TW_W - 1)) - 64'sd1;
    localparam longint PI_Q30 = 64'sd3373259426;

    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    // Fixed-point (Q30) Taylor series keeps ROM construction free of real arithmetic.
    function automatic logic signed [TW_W-1:0] rom_val(input int j);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint prod;
        if (j >= QN) return '0;
        x    = (64'sd2 * PI_Q30 * longint'(j)) >>> LOG2N;
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        acc  = term;
        for (int i = 1; i <= 10; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
            acc  = acc + term;
        end
        prod = (AMP * acc + (64'sd1 <<< 29)) >>> 30;
        return TW_W'(prod);
    endfunction

    function automatic logic signed [RW-1:0] round_shift(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
`ifdef ROT_ROUND_EN
        t = v + SW'(64'sd1 <<< (TW_W - 2));
`else
        t = v;
`endif
        return RW'(t >>> SH);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [RW-1:0] v);
        if (v > SAT_MAX) return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
        else return DATA_W'(v);
    endfunction

    logic signed [TW_W-1:0] rom [QN+1];
    for (genvar j = 0; j <= QN; j++) begin : g_rom
        localparam logic signed [TW_W-1:0] CJ = rom_val(j);
        assign rom[j] = CJ;
    end

    // ---- Stage 1: capture sample, index, mode and valid ----
    logic signed [DATA_W-1:0] xi_p1, xq_p1;
    logic [LOG2N-1:0]         idx_p1;
    logic                     inv_p1, vld_p1;

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else if (bus.en) vld_p1 <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (bus.en) begin
            xi_p1  <= bus.in_data_i;
            xq_p1  <= bus.in_data_q;
            idx_p1 <= bus.fi_idx;
            inv_p1 <= bus.inv;
        end
    end

    logic [1:0]    qd_p1;
    logic [AW-1:0] addr_r_p1, addr_rb_p1;

    assign qd_p1      = idx_p1[LOG2N-1 -: 2];
    assign addr_r_p1  = {1'b0, idx_p1[LOG2N-3:0]};
    assign addr_rb_p1 = AW'(QN) - addr_r_p1;

    // ---- Stage 2: ROM read and quadrant fold ----
    logic signed [TW_W-1:0] ca_p1, cb_p1, c_nx, s_nx;

    assign ca_p1 = rom[addr_r_p1];
    assign cb_p1 = rom[addr_rb_p1];

    always_comb begin
        c_nx = ca_p1;
        s_nx = cb_p1;
        unique case (qd_p1)
            2'd0: begin c_nx = ca_p1;  s_nx = cb_p1;  end
            2'd1: begin c_nx = -cb_p1; s_nx = ca_p1;  end
            2'd2: begin c_nx = -ca_p1; s_nx = -cb_p1; end
            default: begin c_nx = cb_p1; s_nx = -ca_p1; end
        endcase
    end

    logic signed [TW_W-1:0]   c_p2, s_p2;
    logic signed [DATA_W-1:0] xi_p2, xq_p2;
    logic [LOG2N-1:0]         idx_p2;
    logic                     inv_p2, vld_p2;

    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else if (bus.en) vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        if (bus.en) begin
            c_p2   <= c_nx;
            s_p2   <= s_nx;
            xi_p2  <= xi_p1;
            xq_p2  <= xq_p1;
            idx_p2 <= idx_p1;
            inv_p2 <= inv_p1;
        end
    end

    // ---- Stage 3: four partial products ----
    logic signed [PW-1:0] pic_p3, pqc_p3, pis_p3, pqs_p3;
    logic [LOG2N-1:0]     idx_p3;
    logic                 inv_p3, vld_p3;

    always_ff @(posedge clk) begin
        if (rst) vld_p3 <= 1'b0;
        else if (bus.en) vld_p3 <= vld_p2;
    end

    always_ff @(posedge clk) begin
        if (bus.en) begin
            pic_p3 <= PW'(xi_p2) * PW'(c_p2);
            pqc_p3 <= PW'(xq_p2) * PW'(c_p2);
            pis_p3 <= PW'(xi_p2) * PW'(s_p2);
            pqs_p3 <= PW'(xq_p2) * PW'(s_p2);
            idx_p3 <= idx_p2;
            inv_p3 <= inv_p2;
        end
    end

    // ---- Stage 4: combine, scale, saturate, register outputs ----
    logic signed [SW-1:0]     mi_sum, mq_sum, pi_sum, pq_sum;
    logic signed [DATA_W-1:0] mi_res, mq_res, pi_res, pq_res;

    assign mi_sum = SW'(pic_p3) + SW'(pqs_p3);
    assign mq_sum = SW'(pqc_p3) - SW'(pis_p3);
    assign pi_sum = SW'(pic_p3) - SW'(pqs_p3);
    assign pq_sum = SW'(pqc_p3) + SW'(pis_p3);

    assign mi_res = saturate(round_shift(mi_sum));
    assign mq_res = saturate(round_shift(mq_sum));
    assign pi_res = saturate(round_shift(pi_sum));
    assign pq_res = saturate(round_shift(pq_sum));

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid        <= 1'b0;
            bus.out_idx          <= '0;
            bus.out_data_minus_i <= '0;
            bus.out_data_minus_q <= '0;
            bus.out_data_plus_i  <= '0;
            bus.out_data_plus_q  <= '0;
        end else if (bus.en) begin
            bus.out_valid <= vld_p3;
            bus.out_idx   <= idx_p3;
            if (inv_p3) begin
                bus.out_data_minus_i <= pi_res;
                bus.out_data_minus_q <= pq_res;
                bus.out_data_plus_i  <= mi_res;
                bus.out_data_plus_q  <= mq_res;
            end else begin
                bus.out_data_minus_i <= mi_res;
                bus.out_data_minus_q <= mq_res;
                bus.out_data_plus_i  <= pi_res;
                bus.out_data_plus_q  <= pq_res;
            end
        end
    end
endmodule

// File: tb/tb_mult_complex_e_pipe.sv
// Self-checking bench for mult_complex_e_pipe: directed steps plus a real-valued reference scoreboard.
`timescale 1ns/1ps
module tb_mult_complex_e_pipe;
    localparam int  LOG2N  = 4;
    localparam int  DATA_W = 16;
    localparam int  TW_W   = 16;
    localparam int  N      = 16;
    localparam real PI     = 3.14159265358979323846;
    localparam real AMP    = 32767.0;

`ifdef ROT_ROUND_EN
    localparam int T1 = 749, QM_I = 749, QM_Q = -749, QP_I = -749, QP_Q = 749;
`else
    localparam int T1 = 748, QM_I = 748, QM_Q = -749, QP_I = -749, QP_Q = 748;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_complex_e_pipe_if #(.LOG2N(LOG2N), .DATA_W(DATA_W)) bus ();

    mult_complex_e_pipe #(.LOG2N(LOG2N), .DATA_W(DATA_W), .TW_W(TW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint mi, mq, pi, pq;
        int     idx;
        int     tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   adv_cnt = 0;
    bit   last_adv = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    // Scale by 2^-(TW_W-1) with floor (or round half up), then clamp to the output range.
    function automatic longint scale_ref(input longint v);
        real    t;
        longint r;
        t = real'(v);
`ifdef ROT_ROUND_EN
        t = t + 16384.0;
`endif
        r = longint'($floor(t / 32768.0));
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic exp_t model(input longint xi, input longint xq, input int k, input bit inv, input int tag);
        exp_t   e;
        real    th;
        longint c, s, t;
        th = 2.0 * PI * real'(k) / real'(N);
        c  = longint'(AMP * $cos(th));
        s  = longint'(AMP * $sin(th));
        e.mi  = scale_ref(xi * c + xq * s);
        e.mq  = scale_ref(xq * c - xi * s);
        e.pi  = scale_ref(xi * c - xq * s);
        e.pq  = scale_ref(xq * c + xi * s);
        if (inv) begin
            t = e.mi; e.mi = e.pi; e.pi = t;
            t = e.mq; e.mq = e.pq; e.pq = t;
        end
        e.idx = k;
        e.tag = tag;
        return e;
    endfunction

    // Accepted samples enter the scoreboard tagged with the enabled-edge count.
    always @(posedge clk) begin
        if (rst) begin
            sbq.delete();
            last_adv = 1'b0;
        end else begin
            last_adv = bus.en;
            if (bus.en) begin
                adv_cnt++;
                if (bus.in_valid)
                    sbq.push_back(model(longint'(bus.in_data_i), longint'(bus.in_data_q),
                                        int'(bus.fi_idx), bus.inv, adv_cnt));
            end
        end
    end

    exp_t got;
    always @(negedge clk) begin
        if (last_adv) begin
            if (sbq.size() > 0 && sbq[0].tag + 3 == adv_cnt) begin
                got = sbq.pop_front();
                check("sb_valid", bus.out_valid, 1);
                check("sb_idx", bus.out_idx, got.idx);
                check("sb_minus_i", bus.out_data_minus_i, got.mi);
                check("sb_minus_q", bus.out_data_minus_q, got.mq);
                check("sb_plus_i", bus.out_data_plus_i, got.pi);
                check("sb_plus_q", bus.out_data_plus_q, got.pq);
            end else begin
                check("sb_idle", bus.out_valid, 0);
            end
        end
    end

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    task automatic drive(input bit v, input bit iv, input int xi, input int xq, input int k);
        bus.in_valid  = v;
        bus.inv       = iv;
        bus.in_data_i = 16'(xi);
        bus.in_data_q = 16'(xq);
        bus.fi_idx    = 4'(k);
    endtask

    // One isolated sample; returns at the negedge where it must be on the outputs.
    task automatic pulse(input bit iv, input int xi, input int xq, input int k);
        @(negedge clk);
        drive(1'b1, iv, xi, xq, k);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("lat_c1", bus.out_valid, 0);
        @(negedge clk);
        check("lat_c2", bus.out_valid, 0);
        @(negedge clk);
        check("lat_c3", bus.out_valid, 0);
        @(negedge clk);
        check("lat_c4", bus.out_valid, 1);
        check("lat_idx", bus.out_idx, k);
    endtask

    task automatic check_outs(input string tag, input int mi, input int mq, input int pi, input int pq);
        check({tag, "_minus_i"}, bus.out_data_minus_i, mi);
        check({tag, "_minus_q"}, bus.out_data_minus_q, mq);
        check({tag, "_plus_i"}, bus.out_data_plus_i, pi);
        check({tag, "_plus_q"}, bus.out_data_plus_q, pq);
    endtask

    logic signed [DATA_W-1:0] snap_mi, snap_mq, snap_pi, snap_pq;
    logic [LOG2N-1:0]         snap_idx;
    logic                     snap_vld;

    initial begin
        rst    = 1'b1;
        bus.en = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0);

        repeat (3) begin
            @(negedge clk);
            check("rst_valid", bus.out_valid, 0);
            check("rst_idx", bus.out_idx, 0);
            check_outs("rst", 0, 0, 0, 0);
        end
        rst    = 1'b0;
        bus.en = 1'b1;

        pulse(1'b0, 749, 749, 0);
        check_outs("k0", T1, T1, T1, T1);

        pulse(1'b0, 749, 749, 4);
        check_outs("quad", QM_I, QM_Q, QP_I, QP_Q);

        pulse(1'b0, -32768, -32768, 2);
        check_outs("sat", -32768, 0, 0, -32768);

        pulse(1'b1, 749, 749, 4);
        check_outs("inv", QP_I, QP_Q, QM_I, QM_Q);

        pulse(1'b0, rnd16(), rnd16(), 8);
        pulse(1'b0, rnd16(), rnd16(), 15);
        pulse(1'b1, 32767, -32768, 15);

        // Back-to-back sweep of k = 0..7.
        for (int m = 0; m < 12; m++) begin
            @(negedge clk);
            if (m >= 4) begin
                check("sweep_valid", bus.out_valid, 1);
                check("sweep_idx", bus.out_idx, m - 4);
            end else begin
                check("sweep_pre", bus.out_valid, 0);
            end
            if (m < 8) drive(1'b1, 1'b0, rnd16(), rnd16(), m);
            else bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("sweep_post", bus.out_valid, 0);

        // Random stream with a 3-cycle stall in the middle.
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (m == 10) begin
                snap_mi  = bus.out_data_minus_i;
                snap_mq  = bus.out_data_minus_q;
                snap_pi  = bus.out_data_plus_i;
                snap_pq  = bus.out_data_plus_q;
                snap_idx = bus.out_idx;
                snap_vld = bus.out_valid;
                bus.en   = 1'b0;
            end else if (m >= 11 && m <= 13) begin
                check("stall_valid", bus.out_valid, snap_vld);
                check("stall_idx", bus.out_idx, snap_idx);
                check_outs("stall", int'(snap_mi), int'(snap_mq), int'(snap_pi), int'(snap_pq));
                if (m == 13) bus.en = 1'b1;
            end
            drive(($urandom_range(0, 9) < 7), 1'($urandom), rnd16(), rnd16(), int'($urandom_range(0, N - 1)));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("stream_drained", sbq.size(), 0);

        // Reset with three samples in flight.
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, rnd16(), rnd16(), m + 5);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", bus.out_valid, 0);
        check_outs("mid_rst", 0, 0, 0, 0);
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            check("mid_rst_flushed", bus.out_valid, 0);
        end
        pulse(1'b0, 749, 749, 4);
        check_outs("post_rst", QM_I, QM_Q, QP_I, QP_Q);

        repeat (6) @(negedge clk);
        check("final_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_complex_e_pipe.md
Name: mult_complex_e_pipe

Overview:
Pipelined complex rotator for the FFT/OFDM datapath. Each accepted sample x is multiplied by both e^(-j2πk/N) and e^(+j2πk/N), with k = twiddle index and N = 2^LOG2N. Twiddles come from an internal quarter-wave cosine ROM, and outputs are rounded and saturated. It is the parametrised successor of multComplexE and adds valid tagging, a pipeline stall, a runtime inverse mode, saturation and index passthrough.

Parameters:
LOG2N, 4, log2 of FFT size N; LOG2N >= 3
DATA_W, 16, signed width of in/out I and Q
TW_W, 16, signed twiddle width; amplitude A = 2^(TW_W-1)-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  pipeline clock-enable; 0 freezes every stage
in_valid  in  1  sample on in_data_* / fi_idx is valid
inv  in  1  0: forward; 1: inverse (minus/plus outputs swapped), sampled with the data
in_data_i  in  DATA_W  signed real part of x
in_data_q  in  DATA_W  signed imaginary part of x
fi_idx  in  LOG2N  twiddle index k, unsigned, mod N
out_data_minus_i  out  DATA_W  Re(x·e^(-jθ)), or Re(x·e^(+jθ)) if inv
out_data_minus_q  out  DATA_W  Im of the same product
out_data_plus_i  out  DATA_W  Re(x·e^(+jθ)), or Re(x·e^(-jθ)) if inv
out_data_plus_q  out  DATA_W  Im of the same product
out_idx  out  LOG2N  fi_idx of the emerging sample
out_valid  out  1  outputs valid

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. Reset wins over en.
- Reset values: all out_data_*, out_idx and out_valid = 0. Every internal valid bit = 0.
- ROM: C[j] = round(A·cos(2πj/N)) for j = 0..N/4, giving N/4+1 entries. Built at elaboration from a constant function. C[N/4] is forced to 0.
- Folding: quadrant qd = k[LOG2N-1:LOG2N-2] and r = k mod N/4.
  - qd0: c = C[r], s = C[N/4-r]
  - qd1: c = -C[N/4-r], s = C[r]
  - qd2: c = -C[r], s = -C[N/4-r]
  - qd3: c = C[N/4-r], s = -C[r]
- Pipeline, 4 stages, each advancing only when en = 1:
  - S1: register x, k, inv, valid; compute ROM addresses.
  - S2: ROM read; apply quadrant sign to get c, s.
  - S3: four products xi·c, xq·c, xi·s, xq·s, each DATA_W+TW_W bits.
  - S4: add/sub at DATA_W+TW_W+1 bits, then scale, saturate and register.
    - minus: I = xi·c + xq·s, Q = xq·c − xi·s
    - plus: I = xi·c − xq·s, Q = xq·c + xi·s
    - inv = 1 swaps the minus/plus assignments at the output register.
- Latency: exactly 4 cycles with en held 1. out_valid is in_valid delayed through 4 enabled edges.
- Bubbles: stages move regardless of valid. Outputs update on every enabled edge. When out_valid = 0, the output data is don't-care.
- en = 0: all stages, outputs and out_valid hold their values.
- Scaling: arithmetic shift right by TW_W-1 (floor) unless ROT_ROUND_EN is defined.
- Saturation: results are clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Wrap-around is never allowed.
- Index wrap: k = N-1 is valid and behaves like θ = −2π/N. k = N/2 gives c = −A, s = 0.
- Reset mid-stream: in-flight samples are discarded. out_valid is 0 on the cycle after reset and stays 0 until 4 enabled cycles after the next in_valid.

Optional Feature:
ROT_ROUND_EN
- Defined: add 2^(TW_W-2) before the shift (round half up), then saturate.
- Undefined: truncate by floor shift only; the adder is not instantiated.

Test Plan:
- Reset and latency: rst 1 for 3 clocks, then en = 1 and in_valid pulse with x = 749+j749, k = 0 → out_valid high exactly 4 clocks later. Minus = plus = (748, 748) truncated, or (749, 749) with ROT_ROUND_EN. All outputs read 0 while in reset.
- Quadrant: x = 749+j749, k = 4, N = 16, truncated → minus = (748, −749), plus = (−749, 748). Rounded → minus (749, −749), plus (−749, 749).
- Saturation: x = −32768−j32768, k = 2 (45°) → minus_i = −32768, minus_q = 0, plus_i = 0, plus_q = −32768 (the raw value of about −46340 is clamped).
- Back-to-back sweep: k = 0..7 on consecutive cycles → 8 consecutive out_valid cycles, out_idx = 0..7 in order. Each result matches the reference model within 1 LSB.
- Stall and inv: a stream with en dropped low for 3 cycles mid-stream → outputs and out_valid frozen, no sample lost or duplicated. inv = 1 with k = 4 → the minus/plus values from the quadrant test are swapped.
- Reset mid-operation: assert rst for 1 cycle while 3 samples are in flight → none emerge. The next sample emerges after exactly 4 clocks.
